// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin share of one block-memory port between two requesters
module bram_port_arbiter #(
    parameter int  CAPACITY_BYTES = 128,
    parameter int  BYTES_PER_WORD = 4,
    localparam int WORD_BITS      = BYTES_PER_WORD * 8,
    localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [ADDR_BITS-1:0]      req0_address,
    input  logic [WORD_BITS-1:0]      req0_wr_data,
    input  logic [BYTES_PER_WORD-1:0] req0_wr_en,
    output logic                      rsp0_valid,
    output logic [WORD_BITS-1:0]      rsp0_rd_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [ADDR_BITS-1:0]      req1_address,
    input  logic [WORD_BITS-1:0]      req1_wr_data,
    input  logic [BYTES_PER_WORD-1:0] req1_wr_en,
    output logic                      rsp1_valid,
    output logic [WORD_BITS-1:0]      rsp1_rd_data,
    output logic [ADDR_BITS-1:0]      mem_address,
    output logic                      mem_rd_en,
    output logic [WORD_BITS-1:0]      mem_wr_data,
    output logic [BYTES_PER_WORD-1:0] mem_wr_en,
    input  logic [WORD_BITS-1:0]      mem_rd_data
);

    logic ptr;
    logic gnt0, gnt1;

    // grant from valids and pointer, then steer the granted payload onto the memory port
    always_comb begin
        gnt0        = req0_valid & (~req1_valid | ~ptr);
        gnt1        = req1_valid & ~gnt0;
        req0_ready  = gnt0;
        req1_ready  = gnt1;
        mem_address = gnt0 ? req0_address : gnt1 ? req1_address : '0;
        mem_wr_data = gnt0 ? req0_wr_data : gnt1 ? req1_wr_data : '0;
        mem_wr_en   = gnt0 ? req0_wr_en   : gnt1 ? req1_wr_en   : '0;
        mem_rd_en   = (gnt0 | gnt1) & ~|mem_wr_en;
    end

    // pointer moves to the loser on each accept; response valid tags the owner one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            if (gnt0 | gnt1)
                ptr <= gnt0;
            rsp0_valid <= gnt0;
            rsp1_valid <= gnt1;
        end
    end

    assign rsp0_rd_data = mem_rd_data;
    assign rsp1_rd_data = mem_rd_data;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed vector bench with an attached byte-strobed memory
module tb_bram_port_arbiter;

    logic        clk, reset_n;
    logic        req0_valid, req0_ready, rsp0_valid;
    logic [6:0]  req0_address;
    logic [31:0] req0_wr_data, rsp0_rd_data;
    logic [3:0]  req0_wr_en;
    logic        req1_valid, req1_ready, rsp1_valid;
    logic [6:0]  req1_address;
    logic [31:0] req1_wr_data, rsp1_rd_data;
    logic [3:0]  req1_wr_en;
    logic [6:0]  mem_address;
    logic        mem_rd_en;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] v0, a0, d0, w0, v1, a1, d1, w1;
        logic [31:0] rdy0, rdy1, addr, rd_en, wr_en, rsp0, rsp1, chk, data;
    } vec_t;

    vec_t vecs[18];

    bram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_address(req0_address),
        .req0_wr_data(req0_wr_data), .req0_wr_en(req0_wr_en),
        .rsp0_valid(rsp0_valid), .rsp0_rd_data(rsp0_rd_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_address(req1_address),
        .req1_wr_data(req1_wr_data), .req1_wr_en(req1_wr_en),
        .rsp1_valid(rsp1_valid), .rsp1_rd_data(rsp1_rd_data),
        .mem_address(mem_address), .mem_rd_en(mem_rd_en), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // attached memory: byte-strobed write, registered read with one-cycle latency
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wr_en[b]) mem[mem_address[6:2]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
        if (mem_rd_en) mem_rd_data <= mem[mem_address[6:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_address = 0; req0_wr_data = 0; req0_wr_en = 0;
        req1_valid = 0; req1_address = 0; req1_wr_data = 0; req1_wr_en = 0;
    endtask

    initial begin
        //           v0 a0     d0            w0   v1 a1     d1            w1   r0 r1 addr   rd wr    s0 s1 ck data
        vecs[0]  = '{0, 0,     0,            0,   0, 0,     0,            0,   0, 0, 0,     0, 0,    0, 0, 0, 0};
        vecs[1]  = '{1, 'h08,  'hDEADBEEF,   'hF, 0, 0,     0,            0,   1, 0, 'h08,  0, 'hF,  0, 0, 0, 0};
        vecs[2]  = '{1, 'h08,  0,            0,   0, 0,     0,            0,   1, 0, 'h08,  1, 0,    1, 0, 0, 0};
        vecs[3]  = '{0, 0,     0,            0,   0, 0,     0,            0,   0, 0, 0,     0, 0,    1, 0, 1, 'hDEADBEEF};
        vecs[4]  = '{1, 'h00,  'hA0A0A0A0,   'hF, 0, 0,     0,            0,   1, 0, 'h00,  0, 'hF,  0, 0, 0, 0};
        vecs[5]  = '{0, 0,     0,            0,   1, 'h04,  'hB1B1B1B1,   'hF, 0, 1, 'h04,  0, 'hF,  1, 0, 0, 0};
        vecs[6]  = '{0, 0,     0,            0,   1, 'h10,  'h11223344,   'hF, 0, 1, 'h10,  0, 'hF,  0, 1, 0, 0};
        vecs[7]  = '{0, 0,     0,            0,   1, 'h10,  'hAABBCCDD,   'h5, 0, 1, 'h10,  0, 'h5,  0, 1, 0, 0};
        vecs[8]  = '{0, 0,     0,            0,   1, 'h10,  0,            0,   0, 1, 'h10,  1, 0,    0, 1, 0, 0};
        vecs[9]  = '{0, 0,     0,            0,   0, 0,     0,            0,   0, 0, 0,     0, 0,    0, 1, 1, 'h11BB33DD};
        vecs[10] = '{1, 'h20,  'h12345678,   'hF, 0, 0,     0,            0,   1, 0, 'h20,  0, 'hF,  0, 0, 0, 0};
        vecs[11] = '{0, 0,     0,            0,   1, 'h20,  0,            0,   0, 1, 'h20,  1, 0,    1, 0, 0, 0};
        vecs[12] = '{0, 0,     0,            0,   0, 0,     0,            0,   0, 0, 0,     0, 0,    0, 1, 1, 'h12345678};
        vecs[13] = '{1, 'h00,  0,            0,   1, 'h04,  0,            0,   1, 0, 'h00,  1, 0,    0, 0, 0, 0};
        vecs[14] = '{1, 'h00,  0,            0,   1, 'h04,  0,            0,   0, 1, 'h04,  1, 0,    1, 0, 1, 'hA0A0A0A0};
        vecs[15] = '{1, 'h00,  0,            0,   1, 'h04,  0,            0,   1, 0, 'h00,  1, 0,    0, 1, 1, 'hB1B1B1B1};
        vecs[16] = '{1, 'h00,  0,            0,   1, 'h04,  0,            0,   0, 1, 'h04,  1, 0,    1, 0, 1, 'hA0A0A0A0};
        vecs[17] = '{0, 0,     0,            0,   0, 0,     0,            0,   0, 0, 0,     0, 0,    0, 1, 1, 'hB1B1B1B1};

        reset_n = 1'b0;
        idle_inputs();
        #3;
        chk("reset_rsp0_valid", 32'(rsp0_valid), 0);
        chk("reset_rsp1_valid", 32'(rsp1_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0[0]; req0_address = vecs[i].a0[6:0];
            req0_wr_data = vecs[i].d0; req0_wr_en = vecs[i].w0[3:0];
            req1_valid = vecs[i].v1[0]; req1_address = vecs[i].a1[6:0];
            req1_wr_data = vecs[i].d1; req1_wr_en = vecs[i].w1[3:0];
            #1;
            chk($sformatf("v%0d_req0_ready", i), 32'(req0_ready), vecs[i].rdy0);
            chk($sformatf("v%0d_req1_ready", i), 32'(req1_ready), vecs[i].rdy1);
            chk($sformatf("v%0d_mem_address", i), 32'(mem_address), vecs[i].addr);
            chk($sformatf("v%0d_mem_rd_en", i), 32'(mem_rd_en), vecs[i].rd_en);
            chk($sformatf("v%0d_mem_wr_en", i), 32'(mem_wr_en), vecs[i].wr_en);
            chk($sformatf("v%0d_rsp0_valid", i), 32'(rsp0_valid), vecs[i].rsp0);
            chk($sformatf("v%0d_rsp1_valid", i), 32'(rsp1_valid), vecs[i].rsp1);
            if (vecs[i].chk[0])
                chk($sformatf("v%0d_rd_data", i), vecs[i].rsp0[0] ? rsp0_rd_data : rsp1_rd_data, vecs[i].data);
        end

        // reset dropped while a req1 read is being accepted: its response must never appear
        @(negedge clk);
        idle_inputs();
        req1_valid = 1; req1_address = 7'h04;
        #1 chk("rst_rd_req1_ready", 32'(req1_ready), 1);
        #2 reset_n = 1'b0;
        #1 chk("rst_rd_rsp1_now", 32'(rsp1_valid), 0);
        req1_valid = 0;
        @(posedge clk);
        #1 chk("rst_rd_rsp1_edge", 32'(rsp1_valid), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_rd_rsp1_after", 32'(rsp1_valid), 0);

        // a grant to req0 moves the pointer; reset mid-cycle clears the response and the pointer
        @(negedge clk);
        req0_valid = 1; req0_address = 7'h00;
        @(posedge clk);
        #1 chk("rst_ptr_rsp0_before", 32'(rsp0_valid), 1);
        req0_valid = 0;
        #2 reset_n = 1'b0;
        #1 chk("rst_ptr_rsp0_async", 32'(rsp0_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        req0_valid = 1; req0_address = 7'h00;
        req1_valid = 1; req1_address = 7'h04;
        #1 chk("post_rst_req0_ready", 32'(req0_ready), 1);
        chk("post_rst_req1_ready", 32'(req1_ready), 0);
        @(negedge clk);
        #1 chk("post_rst_alt_req1_ready", 32'(req1_ready), 1);
        chk("post_rst_rsp0_valid", 32'(rsp0_valid), 1);
        chk("post_rst_rsp0_data", rsp0_rd_data, 32'hA0A0A0A0);
        @(negedge clk);
        idle_inputs();
        #1 chk("post_rst_rsp1_valid", 32'(rsp1_valid), 1);
        chk("post_rst_rsp1_data", rsp1_rd_data, 32'hB1B1B1B1);
        chk("post_rst_idle_rd_en", 32'(mem_rd_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
